// File: rtl/fb_slave_resp_tx.sv
// freedm_bus slave responder: turns synchronized Numb/Dist/Delay/DelayDist requests
// into preamble + type + payload + CRC-32 frames driven nibble-serially on MII TX.
module fb_slave_resp_tx #(
  parameter int PRE_NIBBLES = 15,
  parameter int IFG_NIBBLES = 24
) (
  input  logic        clk_tx0_25,
  input  logic        rst,
  input  logic        NumbReq,
  input  logic        DistReq,
  input  logic        DelayReq,
  input  logic        DelayDistReq,
  input  logic [7:0]  RxSlaveID,
  input  logic [15:0] RxDelaySum,
  input  logic [7:0]  RxLastSlaveIDPlus1,
  input  logic [7:0]  RxAveSlaveDelay,
  input  logic [7:0]  SlaveDelay,
  output logic [3:0]  MTxD,
  output logic        MTxEn,
  output logic        MTxErr,
  output logic        Busy,
  output logic        FrameSent,
  output logic        PendOvf,
  output logic        StateIdle,
  output logic        StatePre,
  output logic        StateType,
  output logic        StatePay,
  output logic        StateCrc,
  output logic        StateIfg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    TYPE = 3'd2,
    PAY  = 3'd3,
    CRC  = 3'd4,
    IFG  = 3'd5
  } state_t;

  // Reflected (LSB-first) CRC-32 step; its complement read LSB first is the Ethernet FCS.
  function automatic logic [31:0] crcNibble(input logic [31:0] crcIn, input logic [3:0] d);
    logic [31:0] c;
    c = crcIn;
    for (int i = 0; i < 4; i++) begin
      if (c[0] ^ d[i]) begin
        c = (c >> 1) ^ 32'hEDB8_8320;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  logic [3:0]  reqIn_s, sync1_r, sync2_r, sync3_r, rise_s;
  logic [3:0]  pend_r, grant_s, clear_s;
  logic [1:0]  grantIdx_s, typeIdx_r;
  logic        pendOvf_r;
  state_t      state_r, stateNext_s;
  logic [7:0]  cnt_r, cntNext_s;
  logic [31:0] crc_r, crcNext_s, fcs_s;
  logic [15:0] pay_r, payNext_s;
  logic [16:0] delaySum_s;
  logic [7:0]  typeByte_s;
  logic [3:0]  nibNext_s;
  logic        latch_s, sentNext_s, txOn_s;

  assign reqIn_s    = {DelayDistReq, DelayReq, DistReq, NumbReq};
  assign rise_s     = sync2_r & ~sync3_r;
  assign clear_s    = latch_s ? grant_s : 4'b0000;
  assign fcs_s      = ~crc_r;
  assign typeByte_s = {6'b000000, typeIdx_r} + 8'd1;
  assign delaySum_s = {1'b0, RxDelaySum} + {9'd0, SlaveDelay};
  assign MTxErr     = 1'b0;
  assign PendOvf    = pendOvf_r;

  // Request synchronizers, rising-edge history and per-type pending flags.
  always_ff @(posedge clk_tx0_25 or posedge rst) begin
    if (rst) begin
      sync1_r   <= 4'b0000;
      sync2_r   <= 4'b0000;
      sync3_r   <= 4'b0000;
      pend_r    <= 4'b0000;
      pendOvf_r <= 1'b0;
    end else begin
      sync1_r   <= reqIn_s;
      sync2_r   <= sync1_r;
      sync3_r   <= sync2_r;
      pend_r    <= (pend_r & ~clear_s) | rise_s;
      pendOvf_r <= pendOvf_r | (|(rise_s & pend_r & ~clear_s));
    end
  end

  // Fixed-priority arbitration (Numb > Dist > Delay > DelayDist) and winner payload.
  always_comb begin
    grant_s    = 4'b0000;
    grantIdx_s = 2'd0;
    payNext_s  = 16'h0000;
    if (pend_r[0]) begin
      grant_s    = 4'b0001;
      grantIdx_s = 2'd0;
    end else if (pend_r[1]) begin
      grant_s    = 4'b0010;
      grantIdx_s = 2'd1;
    end else if (pend_r[2]) begin
      grant_s    = 4'b0100;
      grantIdx_s = 2'd2;
    end else if (pend_r[3]) begin
      grant_s    = 4'b1000;
      grantIdx_s = 2'd3;
    end else begin
      grant_s    = 4'b0000;
      grantIdx_s = 2'd0;
    end
    case (grantIdx_s)
      2'd0:    payNext_s = {8'h00, RxSlaveID + 8'd1};
      2'd2:    payNext_s = delaySum_s[16] ? 16'hFFFF : delaySum_s[15:0];
      default: payNext_s = {RxAveSlaveDelay, RxLastSlaveIDPlus1};
    endcase
  end

  // Next state/count, then the nibble and CRC for the state being entered so outputs stay registered.
  always_comb begin
    stateNext_s = state_r;
    cntNext_s   = cnt_r + 8'd1;
    latch_s     = 1'b0;
    crcNext_s   = crc_r;
    nibNext_s   = 4'h0;
    sentNext_s  = 1'b0;
    txOn_s      = 1'b0;
    case (state_r)
      IDLE: begin
        cntNext_s = 8'd0;
        if (|pend_r) begin
          stateNext_s = PRE;
          latch_s     = 1'b1;
        end else begin
          stateNext_s = IDLE;
        end
      end
      PRE: begin
        if (cnt_r == 8'(PRE_NIBBLES)) begin
          stateNext_s = TYPE;
          cntNext_s   = 8'd0;
        end else begin
          stateNext_s = PRE;
        end
      end
      TYPE: begin
        if (cnt_r == 8'd1) begin
          stateNext_s = PAY;
          cntNext_s   = 8'd0;
        end else begin
          stateNext_s = TYPE;
        end
      end
      PAY: begin
        if (cnt_r == ((typeIdx_r == 2'd0) ? 8'd1 : 8'd3)) begin
          stateNext_s = CRC;
          cntNext_s   = 8'd0;
        end else begin
          stateNext_s = PAY;
        end
      end
      CRC: begin
        if (cnt_r == 8'd7) begin
          stateNext_s = IFG;
          cntNext_s   = 8'd0;
        end else begin
          stateNext_s = CRC;
        end
      end
      IFG: begin
        // Last gap cycle doubles as the arbitration slot so queued frames keep an exact gap.
        if (cnt_r == 8'(IFG_NIBBLES - 1)) begin
          cntNext_s = 8'd0;
          if (|pend_r) begin
            stateNext_s = PRE;
            latch_s     = 1'b1;
          end else begin
            stateNext_s = IDLE;
          end
        end else begin
          stateNext_s = IFG;
        end
      end
      default: begin
        stateNext_s = IDLE;
        cntNext_s   = 8'd0;
      end
    endcase

    case (stateNext_s)
      PRE: begin
        txOn_s    = 1'b1;
        crcNext_s = 32'hFFFF_FFFF;
        nibNext_s = (cntNext_s == 8'(PRE_NIBBLES)) ? 4'hD : 4'h5;
      end
      TYPE: begin
        txOn_s    = 1'b1;
        nibNext_s = cntNext_s[0] ? typeByte_s[7:4] : typeByte_s[3:0];
        crcNext_s = crcNibble(crc_r, nibNext_s);
      end
      PAY: begin
        txOn_s    = 1'b1;
        nibNext_s = pay_r[{cntNext_s[1:0], 2'b00} +: 4];
        crcNext_s = crcNibble(crc_r, nibNext_s);
      end
      CRC: begin
        txOn_s     = 1'b1;
        nibNext_s  = fcs_s[{cntNext_s[2:0], 2'b00} +: 4];
        sentNext_s = (cntNext_s[2:0] == 3'd7);
      end
      default: begin
        txOn_s    = 1'b0;
        nibNext_s = 4'h0;
      end
    endcase
  end

  // Sequencer state, latched frame contents and registered MII/status outputs.
  always_ff @(posedge clk_tx0_25 or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      crc_r     <= 32'hFFFF_FFFF;
      pay_r     <= 16'h0000;
      typeIdx_r <= 2'd0;
      MTxD      <= 4'h0;
      MTxEn     <= 1'b0;
      Busy      <= 1'b0;
      FrameSent <= 1'b0;
      StateIdle <= 1'b1;
      StatePre  <= 1'b0;
      StateType <= 1'b0;
      StatePay  <= 1'b0;
      StateCrc  <= 1'b0;
      StateIfg  <= 1'b0;
    end else begin
      state_r   <= stateNext_s;
      cnt_r     <= cntNext_s;
      crc_r     <= crcNext_s;
      if (latch_s) begin
        typeIdx_r <= grantIdx_s;
        pay_r     <= payNext_s;
      end
      MTxD      <= nibNext_s;
      MTxEn     <= txOn_s;
      Busy      <= (stateNext_s != IDLE);
      FrameSent <= sentNext_s;
      StateIdle <= (stateNext_s == IDLE);
      StatePre  <= (stateNext_s == PRE);
      StateType <= (stateNext_s == TYPE);
      StatePay  <= (stateNext_s == PAY);
      StateCrc  <= (stateNext_s == CRC);
      StateIfg  <= (stateNext_s == IFG);
    end
  end

endmodule

// File: tb/tb_fb_slave_resp_tx.sv
// Bench for fb_slave_resp_tx: expected frames are queued by the stimulus side and a
// monitor captures every MTxEn burst and compares it with the next queued frame.
module tb_fb_slave_resp_tx;

  localparam int PRE_N = 15;
  localparam int IFG_N = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  reqLvl;
  logic [7:0]  rxSlaveId, rxLast, rxAve, slaveDelay;
  logic [15:0] rxDelaySum;
  logic [3:0]  MTxD;
  logic        MTxEn, MTxErr, Busy, FrameSent, PendOvf;
  logic        StateIdle, StatePre, StateType, StatePay, StateCrc, StateIfg;

  fb_slave_resp_tx #(.PRE_NIBBLES(PRE_N), .IFG_NIBBLES(IFG_N)) dut (
    .clk_tx0_25(clk), .rst(rst),
    .NumbReq(reqLvl[0]), .DistReq(reqLvl[1]), .DelayReq(reqLvl[2]), .DelayDistReq(reqLvl[3]),
    .RxSlaveID(rxSlaveId), .RxDelaySum(rxDelaySum), .RxLastSlaveIDPlus1(rxLast),
    .RxAveSlaveDelay(rxAve), .SlaveDelay(slaveDelay),
    .MTxD(MTxD), .MTxEn(MTxEn), .MTxErr(MTxErr), .Busy(Busy), .FrameSent(FrameSent),
    .PendOvf(PendOvf), .StateIdle(StateIdle), .StatePre(StatePre), .StateType(StateType),
    .StatePay(StatePay), .StateCrc(StateCrc), .StateIfg(StateIfg)
  );

  always #20 clk = ~clk;

  typedef struct packed {
    logic [127:0] nibs;
    logic [7:0]   len;
  } frame_t;

  frame_t       expQ[$];
  int           checks = 0;
  int           errors = 0;
  logic [127:0] lastNibs = '0;
  int           lastLen = 0;
  int           lastGap = 0;
  int           strayCnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference frame built from bytes: type, payload, then Ethernet FCS of type+payload.
  function automatic frame_t model(input int kind, input int id, input int sum, input int sd,
                                   input int last, input int ave);
    int          bytes[$];
    int          s, n, nData;
    logic [31:0] crc, fcs;
    frame_t      f;
    bytes.push_back(kind + 1);
    if (kind == 0) begin
      bytes.push_back((id + 1) % 256);
    end else if (kind == 2) begin
      s = sum + sd;
      if (s > 65535) s = 65535;
      bytes.push_back(s % 256);
      bytes.push_back(s / 256);
    end else begin
      bytes.push_back(last);
      bytes.push_back(ave);
    end
    crc = 32'hFFFF_FFFF;
    nData = bytes.size();
    for (int b = 0; b < nData; b++) begin
      crc = crc ^ 32'(bytes[b]);
      for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
    end
    fcs = ~crc;
    for (int k = 0; k < 4; k++) bytes.push_back(int'((fcs >> (8 * k)) & 32'hFF));
    f = '0;
    n = 0;
    for (int i = 0; i < PRE_N; i++) begin
      f.nibs[n*4 +: 4] = 4'h5;
      n++;
    end
    f.nibs[n*4 +: 4] = 4'hD;
    n++;
    for (int b = 0; b < bytes.size(); b++) begin
      f.nibs[n*4 +: 4] = 4'(bytes[b] % 16);
      f.nibs[(n+1)*4 +: 4] = 4'(bytes[b] / 16);
      n += 2;
    end
    f.len = 8'(n);
    return f;
  endfunction

  function automatic frame_t cur(input int kind);
    return model(kind, int'(rxSlaveId), int'(rxDelaySum), int'(slaveDelay), int'(rxLast), int'(rxAve));
  endfunction

  // Monitor: capture each MTxEn burst and score it against the expected queue.
  initial begin
    logic [127:0] capNibs;
    int           capLen, sentCnt, sentPos, idleRun;
    logic         prevEn, errSeen;
    frame_t       e;
    capNibs = '0; capLen = 0; sentCnt = 0; sentPos = -1; idleRun = 0; prevEn = 1'b0; errSeen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        capNibs = '0; capLen = 0; sentCnt = 0; sentPos = -1; idleRun = 0; prevEn = 1'b0; errSeen = 1'b0;
      end else begin
        if (MTxErr !== 1'b0) errSeen = 1'b1;
        if (MTxEn) begin
          if (!prevEn) lastGap = idleRun;
          idleRun = 0;
          if (capLen < 32) capNibs[capLen*4 +: 4] = MTxD;
          if (FrameSent) begin
            sentCnt++;
            sentPos = capLen;
          end
          capLen++;
        end else begin
          if (FrameSent) strayCnt++;
          idleRun++;
          if (prevEn) begin
            lastNibs = capNibs;
            lastLen  = capLen;
            if (expQ.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected frame: got len %0d nibs %0h, none expected", capLen, capNibs);
            end else begin
              e = expQ.pop_front();
              chk("frame length", 128'(capLen), 128'(e.len));
              chk("frame nibbles", capNibs, e.nibs);
              chk("FrameSent count", 128'(sentCnt), 128'd1);
              chk("FrameSent position", 128'(sentPos), 128'(int'(e.len) - 1));
              chk("MTxErr low", 128'(errSeen), 128'd0);
            end
            capNibs = '0; capLen = 0; sentCnt = 0; sentPos = -1; errSeen = 1'b0;
          end
        end
        prevEn = MTxEn;
      end
    end
  end

  task automatic pulse(input logic [3:0] m);
    @(posedge clk); #2;
    reqLvl = reqLvl | m;
    repeat (4) @(posedge clk);
    #2;
    reqLvl = reqLvl & ~m;
    repeat (4) @(posedge clk);
  endtask

  task automatic waitDone(input string nm, input int budget);
    int n = 0;
    while ((expQ.size() != 0 || Busy === 1'b1 || MTxEn === 1'b1) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " completes"}, 128'(n < budget), 128'd1);
  endtask

  task automatic chkResetOutputs(input string nm);
    chk({nm, " MTxEn"}, 128'(MTxEn), 128'd0);
    chk({nm, " MTxD"}, 128'(MTxD), 128'd0);
    chk({nm, " Busy"}, 128'(Busy), 128'd0);
    chk({nm, " FrameSent"}, 128'(FrameSent), 128'd0);
    chk({nm, " PendOvf"}, 128'(PendOvf), 128'd0);
    chk({nm, " MTxErr"}, 128'(MTxErr), 128'd0);
    chk({nm, " state flags"}, 128'({StateIdle, StatePre, StateType, StatePay, StateCrc, StateIfg}),
        128'(6'b100000));
  endtask

  initial begin
    #(40 * 30000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, highs;
    logic [3:0] m;
    rst = 1'b1; reqLvl = 4'b0000;
    rxSlaveId = 8'h00; rxDelaySum = 16'h0000; rxLast = 8'h00; rxAve = 8'h00; slaveDelay = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chkResetOutputs("reset");
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Numb frame, ID 0x01, with request-to-MTxEn latency
    rxSlaveId = 8'h01;
    expQ.push_back(cur(0));
    @(posedge clk); #2;
    reqLvl[0] = 1'b1;
    lat = 0;
    while (MTxEn !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency 3..4", 128'(lat >= 3 && lat <= 4), 128'd1);
    repeat (4) @(posedge clk);
    #2;
    reqLvl[0] = 1'b0;
    waitDone("numb", 300);
    chk("numb length", 128'(lastLen), 128'd28);
    chk("numb preamble", 128'(lastNibs[63:0]), 128'(64'hD555_5555_5555_5555));
    chk("numb type+payload", 128'(lastNibs[64 +: 16]), 128'(16'h0201));

    // ID wrap
    rxSlaveId = 8'hFF;
    expQ.push_back(cur(0));
    pulse(4'b0001);
    waitDone("idwrap", 300);
    chk("idwrap payload", 128'(lastNibs[72 +: 8]), 128'(8'h00));

    // Delay saturation
    rxDelaySum = 16'hFFF0; slaveDelay = 8'h3E;
    expQ.push_back(cur(2));
    pulse(4'b0100);
    waitDone("delaysat", 300);
    chk("delaysat length", 128'(lastLen), 128'd30);
    chk("delaysat type", 128'(lastNibs[64 +: 8]), 128'(8'h03));
    chk("delaysat payload", 128'(lastNibs[72 +: 16]), 128'(16'hFFFF));

    // Simultaneous Numb + DelayDist
    rxSlaveId = 8'h10; rxLast = 8'h07; rxAve = 8'hA3;
    expQ.push_back(cur(0));
    expQ.push_back(cur(3));
    pulse(4'b1001);
    waitDone("simultaneous", 500);
    chk("simultaneous gap", 128'(lastGap), 128'(IFG_N));
    chk("simultaneous 2nd type", 128'(lastNibs[64 +: 8]), 128'(8'h04));
    chk("simultaneous 2nd length", 128'(lastLen), 128'd30);

    // Random request subsets with random fields, served in priority order
    for (int it = 0; it < 12; it++) begin
      m = 4'($urandom_range(1, 15));
      rxSlaveId = 8'($urandom_range(0, 255));
      rxDelaySum = 16'($urandom_range(0, 65535));
      slaveDelay = 8'($urandom_range(0, 255));
      rxLast = 8'($urandom_range(0, 255));
      rxAve = 8'($urandom_range(0, 255));
      for (int k = 0; k < 4; k++) if (m[k]) expQ.push_back(cur(k));
      pulse(m);
      waitDone("random", 800);
    end

    // Overflow: Dist requested twice while busy with a Numb frame
    rxSlaveId = 8'h42; rxLast = 8'h05; rxAve = 8'h11;
    expQ.push_back(cur(0));
    expQ.push_back(cur(1));
    pulse(4'b0001);
    chk("overflow busy", 128'(Busy), 128'd1);
    chk("overflow not yet", 128'(PendOvf), 128'd0);
    pulse(4'b0010);
    pulse(4'b0010);
    chk("overflow still busy", 128'(Busy), 128'd1);
    chk("overflow PendOvf", 128'(PendOvf), 128'd1);
    waitDone("overflow", 500);
    repeat (100) @(posedge clk);
    chk("overflow sticky", 128'(PendOvf), 128'd1);

    // Reset during CRC
    rxSlaveId = 8'h33;
    expQ.push_back(cur(0));
    pulse(4'b0001);
    n = 0;
    while (StateCrc !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached CRC state", 128'(StateCrc), 128'd1);
    #5;
    rst = 1'b1;
    expQ.delete();
    #1;
    chkResetOutputs("midframe reset");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    highs = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (MTxEn === 1'b1) highs++;
    end
    chk("silent after reset", 128'(highs), 128'd0);

    chk("no stray FrameSent", 128'(strayCnt), 128'd0);
    chk("queue drained", 128'(expQ.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
